// File: rtl/port_link_responder_if.sv
// Bundles the CPU nibble ports and both host-side byte streams of the link responder.
// master = CPU/host side driving requests and data, slave = the responder.
interface port_link_responder_if;
  logic [3:0] cpu_port_out;
  logic [3:0] cpu_port_in;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;

  modport master (
    output cpu_port_out,
    output host_rx_data,
    output host_rx_valid,
    output host_tx_ready,
    input  cpu_port_in,
    input  host_rx_ready,
    input  host_tx_data,
    input  host_tx_valid
  );

  modport slave (
    input  cpu_port_out,
    input  host_rx_data,
    input  host_rx_valid,
    input  host_tx_ready,
    output cpu_port_in,
    output host_rx_ready,
    output host_tx_data,
    output host_tx_valid
  );
endinterface

// File: rtl/port_link_responder.sv
// Responder side of the CPU nibble-port link: toggle-handshake frames move whole bytes
// between the CPU and two host byte FIFOs (RX host->CPU, TX CPU->host).
module port_link_responder #(
  parameter int FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  port_link_responder_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);

  localparam logic [2:0] OP_STATUS = 3'b000;
  localparam logic [2:0] OP_READ   = 3'b001;
  localparam logic [2:0] OP_WRITE  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_WR1,
    ST_WR2,
    ST_WR3
  } state_t;

  state_t       state_q;
  logic [3:0]   req_q;
  logic [3:0]   port_in_q;
  logic [7:0]   shreg_q;

  logic [7:0]         rx_mem [DEPTH];
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

  logic       frame;
  logic [2:0] payload;
  logic       rx_full, rx_nonempty, tx_notfull, tx_nonempty;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] tx_byte;

  // A frame is pending while the registered REQ differs from the ACK we last returned.
  assign frame       = req_q[3] != port_in_q[3];
  assign payload     = req_q[2:0];
  assign rx_full     = rx_cnt_q[FIFO_AW];
  assign rx_nonempty = |rx_cnt_q;
  assign tx_notfull  = !tx_cnt_q[FIFO_AW];
  assign tx_nonempty = |tx_cnt_q;

  assign rx_push = bus.host_rx_valid && !rx_full;
  assign rx_pop  = frame && (state_q == ST_IDLE) && (payload == OP_READ) && rx_nonempty;
  assign tx_push = frame && (state_q == ST_WR3);
  assign tx_pop  = bus.host_tx_ready && tx_nonempty;
  assign tx_byte = {shreg_q[7:2], payload[1:0]};

  assign bus.cpu_port_in   = port_in_q;
  assign bus.host_rx_ready = !rx_full;
  assign bus.host_tx_valid = tx_nonempty;
  assign bus.host_tx_data  = tx_nonempty ? tx_mem[tx_rd_q] : 8'h00;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + CNT_ONE;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - CNT_ONE;
    end
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + CNT_ONE;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= bus.host_rx_data;
    if (tx_push) tx_mem[tx_wr_q] <= tx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PTR_ONE;
      if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_ONE;
      if (tx_push) tx_wr_q <= tx_wr_q + PTR_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // Status flags are taken before this frame's own push/pop takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      port_in_q <= '0;
      shreg_q   <= '0;
      state_q   <= ST_IDLE;
    end else begin
      req_q <= bus.cpu_port_out;
      if (frame) begin
        port_in_q[3] <= req_q[3];
        case (state_q)
          ST_IDLE: begin
            case (payload)
              OP_STATUS: port_in_q[2:0] <= {rx_nonempty, tx_notfull, 1'b1};
              OP_READ: begin
                if (rx_nonempty) begin
                  shreg_q        <= rx_mem[rx_rd_q];
                  port_in_q[2:0] <= {1'b1, tx_notfull, 1'b1};
                  state_q        <= ST_RD1;
                end else begin
                  port_in_q[2:0] <= {1'b0, tx_notfull, 1'b0};
                end
              end
              OP_WRITE: begin
                if (tx_notfull) begin
                  port_in_q[2:0] <= {rx_nonempty, 1'b1, 1'b1};
                  state_q        <= ST_WR1;
                end else begin
                  port_in_q[2:0] <= {rx_nonempty, 1'b0, 1'b0};
                end
              end
              default: port_in_q[2:0] <= {rx_nonempty, tx_notfull, 1'b0};
            endcase
          end
          ST_RD1: begin
            port_in_q[2:0] <= shreg_q[7:5];
            state_q        <= ST_RD2;
          end
          ST_RD2: begin
            port_in_q[2:0] <= shreg_q[4:2];
            state_q        <= ST_RD3;
          end
          ST_RD3: begin
            port_in_q[2:0] <= {1'b0, shreg_q[1:0]};
            state_q        <= ST_IDLE;
          end
          ST_WR1: begin
            shreg_q[7:5]   <= payload;
            port_in_q[2:0] <= payload;
            state_q        <= ST_WR2;
          end
          ST_WR2: begin
            shreg_q[4:2]   <= payload;
            port_in_q[2:0] <= payload;
            state_q        <= ST_WR3;
          end
          ST_WR3: begin
            // WRITE was only accepted with TX space, and only the host drains TX.
            shreg_q[1:0]   <= payload[1:0];
            port_in_q[2:0] <= payload;
            state_q        <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_port_link_responder.sv
// Directed bench for port_link_responder: queue-level protocol model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_port_link_responder;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  port_link_responder_if bus();

  port_link_responder #(.FIFO_AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned issue;
    logic        req;
    logic [2:0]  p;
  } frame_t;

  frame_t      pend[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  int unsigned edge_cnt = 0;
  int          mode = 0;
  int          phase = 0;
  int          wr_acc = 0;
  logic [7:0]  rd_byte = 8'h00;
  logic [3:0]  exp_port_in = 4'h0;

  int   checks = 0;
  int   errors = 0;
  bit   checking = 1'b0;
  logic req_bit = 1'b0;
  logic [3:0] rsp;
  logic [7:0] wbytes [4] = '{8'hA5, 8'h3C, 8'hE1, 8'h0F};

  // Model: a frame issued after edge k takes effect at edge k+2, using FIFO occupancy
  // as it was before that edge; host push/pop of the same edge are applied afterwards.
  task automatic model_edge();
    bit rx_full_pre, tx_pop, rx_push, rxne, txnf;
    logic [2:0] r;
    frame_t f;
    edge_cnt++;
    rx_full_pre = rx_q.size() >= DEPTH;
    tx_pop      = bus.host_tx_ready && (tx_q.size() > 0);
    rx_push     = bus.host_rx_valid && !rx_full_pre;
    if (pend.size() > 0 && pend[0].issue + 2 == edge_cnt) begin
      f    = pend.pop_front();
      rxne = rx_q.size() > 0;
      txnf = tx_q.size() < DEPTH;
      r    = 3'b000;
      if (mode == 0) begin
        case (f.p)
          3'd0: r = {rxne, txnf, 1'b1};
          3'd1: begin
            if (rxne) begin
              rd_byte = rx_q.pop_front();
              r = {1'b1, txnf, 1'b1};
              mode = 1;
              phase = 1;
            end else begin
              r = {1'b0, txnf, 1'b0};
            end
          end
          3'd2: begin
            if (txnf) begin
              r = {rxne, 1'b1, 1'b1};
              mode = 2;
              phase = 1;
              wr_acc = 0;
            end else begin
              r = {rxne, 1'b0, 1'b0};
            end
          end
          default: r = {rxne, txnf, 1'b0};
        endcase
      end else if (mode == 1) begin
        if (phase == 1) r = 3'(rd_byte / 32);
        else if (phase == 2) r = 3'((rd_byte / 4) % 8);
        else begin
          r = 3'(rd_byte % 4);
          mode = 0;
        end
        phase++;
      end else begin
        r = f.p;
        if (phase < 3) begin
          wr_acc = wr_acc * 8 + int'(f.p);
          phase++;
        end else begin
          tx_q.push_back(8'(wr_acc * 4 + int'(f.p) % 4));
          mode = 0;
        end
      end
      exp_port_in = {f.req, r};
    end
    if (tx_pop) void'(tx_q.pop_front());
    if (rx_push) rx_q.push_back(bus.host_rx_data);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend.delete();
      rx_q.delete();
      tx_q.delete();
      mode = 0;
      phase = 0;
      exp_port_in = 4'h0;
    end else begin
      model_edge();
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      checks++;
      if (bus.cpu_port_in !== exp_port_in) begin
        errors++;
        $display("FAIL cpu_port_in: got %b expected %b (edge %0d)", bus.cpu_port_in, exp_port_in, edge_cnt);
      end
      checks++;
      if (bus.host_rx_ready !== (rx_q.size() < DEPTH)) begin
        errors++;
        $display("FAIL host_rx_ready: got %b expected %b (edge %0d)", bus.host_rx_ready, (rx_q.size() < DEPTH), edge_cnt);
      end
      checks++;
      if (bus.host_tx_valid !== (tx_q.size() > 0)) begin
        errors++;
        $display("FAIL host_tx_valid: got %b expected %b (edge %0d)", bus.host_tx_valid, (tx_q.size() > 0), edge_cnt);
      end
      if (tx_q.size() > 0) begin
        checks++;
        if (bus.host_tx_data !== tx_q[0]) begin
          errors++;
          $display("FAIL host_tx_data: got %h expected %h (edge %0d)", bus.host_tx_data, tx_q[0], edge_cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cpu_frame(input logic [2:0] p, output logic [3:0] resp);
    frame_t f;
    @(negedge clk);
    req_bit = ~req_bit;
    bus.cpu_port_out = {req_bit, p};
    f.issue = edge_cnt;
    f.req = req_bit;
    f.p = p;
    pend.push_back(f);
    repeat (2) @(negedge clk);
    resp = bus.cpu_port_in;
    $display("frame payload=%b -> cpu_port_in=%b", p, resp);
  endtask

  task automatic frame_chk(input string name, input logic [2:0] p, input logic [2:0] exp);
    logic [3:0] r;
    cpu_frame(p, r);
    chk(name, {5'b0, r[2:0]}, {5'b0, exp});
  endtask

  task automatic host_push(input logic [7:0] b);
    @(negedge clk);
    bus.host_rx_valid = 1'b1;
    bus.host_rx_data  = b;
    @(negedge clk);
    bus.host_rx_valid = 1'b0;
    $display("host push %h", b);
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic [3:0] r;
    cpu_frame(3'b010, r);
    chk("write_ok", {7'b0, r[0]}, 8'h01);
    frame_chk("wr_echo1", b[7:5], b[7:5]);
    frame_chk("wr_echo2", b[4:2], b[4:2]);
    frame_chk("wr_echo3", {1'b0, b[1:0]}, {1'b0, b[1:0]});
  endtask

  initial begin
    bus.cpu_port_out  = 4'h0;
    bus.host_rx_valid = 1'b0;
    bus.host_rx_data  = 8'h00;
    bus.host_tx_ready = 1'b0;

    @(negedge clk);
    #1 rst_n = 1'b0;
    checking = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_port_in", {4'b0, bus.cpu_port_in}, 8'h00);
    chk("reset_rx_ready", {7'b0, bus.host_rx_ready}, 8'h01);
    chk("reset_tx_valid", {7'b0, bus.host_tx_valid}, 8'h00);
    chk("reset_tx_data", bus.host_tx_data, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cpu_frame(3'b000, rsp);
    chk("status_resp", {4'b0, rsp}, 8'h0B);
    repeat (3) @(negedge clk);
    chk("status_hold", {4'b0, bus.cpu_port_in}, 8'h0B);

    host_push(8'hB6);
    frame_chk("read_b6", 3'b001, 3'b111);
    frame_chk("rd1_b6", 3'b111, 3'b101);
    frame_chk("rd2_b6", 3'b111, 3'b101);
    frame_chk("rd3_b6", 3'b111, 3'b010);

    frame_chk("write_cmd", 3'b010, 3'b011);
    frame_chk("wr1", 3'b011, 3'b011);
    frame_chk("wr2", 3'b100, 3'b100);
    frame_chk("wr3", 3'b001, 3'b001);
    chk("tx_valid_rise", {7'b0, bus.host_tx_valid}, 8'h01);
    chk("tx_data_71", bus.host_tx_data, 8'h71);
    @(negedge clk);
    bus.host_tx_ready = 1'b1;
    @(negedge clk);
    bus.host_tx_ready = 1'b0;
    chk("tx_valid_drop", {7'b0, bus.host_tx_valid}, 8'h00);

    frame_chk("read_empty", 3'b001, 3'b010);
    frame_chk("status_idle", 3'b000, 3'b011);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) chk("rx_full_ready", {7'b0, bus.host_rx_ready}, 8'h00);
      bus.host_rx_valid = 1'b1;
      bus.host_rx_data  = 8'(8'h11 * (i + 1));
      $display("host push attempt %h", bus.host_rx_data);
    end
    @(negedge clk);
    bus.host_rx_valid = 1'b0;
    chk("rx_still_full", {7'b0, bus.host_rx_ready}, 8'h00);

    for (int i = 0; i < 4; i++) write_byte(wbytes[i]);
    frame_chk("write_full", 3'b010, 3'b100);
    frame_chk("status_full", 3'b000, 3'b101);
    @(negedge clk);
    bus.host_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {7'b0, bus.host_tx_valid}, 8'h01);
      chk($sformatf("drain_%0d", i), bus.host_tx_data, wbytes[i]);
      $display("host pop %h", bus.host_tx_data);
      @(negedge clk);
    end
    bus.host_tx_ready = 1'b0;
    chk("drain_empty", {7'b0, bus.host_tx_valid}, 8'h00);

    @(negedge clk);
    bus.cpu_port_out = {req_bit, 3'b001};
    repeat (5) @(negedge clk);
    chk("no_toggle_hold", {4'b0, bus.cpu_port_in}, {4'b0, req_bit, 3'b101});
    frame_chk("unknown_op", 3'b110, 3'b110);

    frame_chk("read_11", 3'b001, 3'b111);
    frame_chk("rd1_11", 3'b000, 3'b000);
    frame_chk("rd2_11", 3'b000, 3'b100);
    frame_chk("rd3_11", 3'b000, 3'b001);

    frame_chk("write_pre_rst", 3'b010, 3'b111);
    frame_chk("wr1_pre_rst", 3'b101, 3'b101);
    frame_chk("wr2_pre_rst", 3'b010, 3'b010);
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.cpu_port_out = 4'h0;
    req_bit = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_port_in", {4'b0, bus.cpu_port_in}, 8'h00);
    chk("midrst_tx_valid", {7'b0, bus.host_tx_valid}, 8'h00);
    chk("midrst_rx_ready", {7'b0, bus.host_rx_ready}, 8'h01);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_no_tx", {7'b0, bus.host_tx_valid}, 8'h00);
    cpu_frame(3'b000, rsp);
    chk("post_rst_status", {4'b0, rsp}, 8'h0B);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: time limit reached before the sequence completed");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/port_link_responder.md
Name: port_link_responder

Overview:
- Host-side partner of the CPU's 4-bit I/O ports.
- Connects to the CPU `port_output` (request) and `port_input` (response) and implements a toggle-handshake framed protocol over them. The CPU is the initiator; this block is the responder.
- Moves whole bytes in both directions: host→CPU through an RX FIFO, CPU→host through a TX FIFO.
- On the host side, each FIFO uses a valid/ready byte interface.

Parameters:
- FIFO_AW, 2, log2 of each FIFO's depth (depth = 2**FIFO_AW, 4 by default).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_port_out  in  4  CPU `port_output`; [3]=REQ toggle, [2:0]=payload.
- cpu_port_in  out  4  to CPU `port_input`; [3]=ACK, [2:0]=response.
- host_rx_data  in  8  byte for the CPU.
- host_rx_valid  in  1  host_rx_data valid.
- host_rx_ready  out  1  RX FIFO not full; push when valid&ready.
- host_tx_data  out  8  head byte of the TX FIFO.
- host_tx_valid  out  1  TX FIFO not empty.
- host_tx_ready  in  1  host consumes; pop when valid&ready.

Behaviour:
- Reset (async assert, sync release):
  - cpu_port_in=4'b0000; registered copy req_q=4'b0000.
  - State IDLE; both FIFOs empty.
  - host_rx_ready=1; host_tx_valid=0; host_tx_data=8'h00.
  - Reset mid-transaction discards the partial byte and clears both FIFOs.
- Frame detection:
  - req_q registers cpu_port_out every cycle.
  - A frame is present in the cycle where req_q[3] != cpu_port_in[3].
  - On the following edge: response[2:0] is written and ACK := req_q[3], in the same edge.
  - Response is therefore visible 2 clocks after the CPU writes the port.
  - Payload changes without a REQ toggle are ignored. Exactly one frame is processed per toggle.
- Status nibble S = {rx_nonempty, tx_notfull, ok}, where rx_nonempty and tx_notfull are sampled before the frame's own push/pop.
- States:
  - IDLE: payload is the opcode.
    - 3'b000 STATUS: respond S with ok=1; stay IDLE.
    - 3'b001 READ:
      - If RX is non-empty: pop the head into shreg, respond S with ok=1, go to RD1.
      - Else: respond ok=0, stay IDLE.
    - 3'b010 WRITE:
      - If TX is not full: respond ok=1, go to WR1.
      - Else: respond ok=0, stay IDLE.
    - Any other opcode: respond S with ok=0, stay IDLE.
  - RD1: respond shreg[7:5] → RD2.
  - RD2: respond shreg[4:2] → RD3.
  - RD3: respond {1'b0, shreg[1:0]} → IDLE. The CPU payload is ignored in all RD states.
  - WR1: shreg[7:5] := payload → WR2.
  - WR2: shreg[4:2] := payload → WR3.
  - WR3: shreg[1:0] := payload[1:0], push shreg into TX → IDLE.
    - In every WR state the response echoes the payload.
    - Space is guaranteed at WR3: the only consumer of TX is the host, so free space never shrinks after WRITE acceptance.
- FIFOs:
  - Synchronous, depth 2**FIFO_AW; pointers wrap modulo depth; a count of FIFO_AW+1 bits gives full/empty.
  - host_rx_ready = !rx_full, from the registered count only. When the FIFO is full, a push is refused even if the CPU pops in the same cycle.
  - A host push and a CPU pop in the same cycle are both honoured; the count is unchanged.
  - TX: a CPU push (WR3) and a host pop in the same cycle are both honoured.
  - host_tx_data shows the head; it is valid only while host_tx_valid=1.
- Ordering: FIFO order is preserved in each direction; no byte is lost or duplicated.

Test Plan:
- Reset, then STATUS:
  - Stimulus: assert rst_n=0, release, then drive cpu_port_out 4'b0000→4'b1000.
  - Required: two cycles after the toggle, cpu_port_in=4'b1011 (ACK=1, rx_nonempty=0, tx_notfull=1, ok=1). Without a further toggle, cpu_port_in holds.
- Host→CPU byte:
  - Stimulus: push 8'hB6; CPU sends READ, then 3 data frames.
  - Required responses: 3'b111 (ok with rx_nonempty=1), 3'b101, 3'b101, 3'b010. host_rx_ready stays 1.
- CPU→host byte:
  - Stimulus: WRITE, then payloads 3'b011, 3'b100, 3'b001.
  - Required: host_tx_valid rises with host_tx_data=8'h71, and drops after one cycle of host_tx_ready=1.
- Full/empty:
  - Stimulus: push 5 RX bytes while the CPU is idle; separately send READ with RX empty.
  - Required: after 4 pushes, host_rx_ready=0 and the 5th push is refused. READ with RX empty returns ok=0 and the block stays IDLE.
- TX full:
  - Stimulus: 4 WRITEs with host_tx_ready=0, then a 5th WRITE; then raise host_tx_ready.
  - Required: the 5th WRITE returns 3'b100 with ok=0. Bytes drain in the order written.
- Robustness:
  - Stimulus: change the payload with no REQ toggle; unknown opcode 3'b110; rst_n low after WR2.
  - Required: no frame is processed for the untoggled change. The unknown opcode gives ok=0. After the reset there is no TX push and the block is in IDLE.
